manchester_tx_serializer: RTL

- Downstream stage of the 8-bit Manchester encoder. Takes its 16-bit encoded word (two half-bits per data bit, MSB pair first) through a valid/ready handshake.
- Checks that every bit pair is a legal Manchester symbol, then drives the word onto a single serial line.
- Each frame is a fixed alternating preamble followed by the 16 data half-bits, with a programmable half-bit period and an inter-frame idle gap.
- The block does not care which bit convention the encoder uses. It only rejects the illegal pairs 00 and 11.

---
 rtl/manchester_pkg.sv | 38 +++
 rtl/manchester_tx_serializer_timer.sv | 28 ++
 rtl/manchester_tx_serializer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/manchester_pkg.sv
// Shared Manchester definitions: FSM state codes,
// legal symbol pairs, preamble pattern, word check.
package manchester_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_PRE  = 2'd1;
  localparam state_t S_DATA = 2'd2;
  localparam state_t S_GAP  = 2'd3;

  localparam logic [1:0] PAIR_ZERO = 2'b01;
  localparam logic [1:0] PAIR_ONE  = 2'b10;

  // Preamble pair, indexed by half-bit parity:
  // odd countdown index drives 1, even drives 0.
  localparam logic [1:0] PRE_PAIR = 2'b10;

  localparam int MAX_W = 64;

  // 1 when every pair in word[nbits-1:0] is 01 or 10.
  function automatic logic is_valid_manchester(
    input logic [MAX_W-1:0] word,
    input int               nbits
  );
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < MAX_W / 2; k++) begin
      if (2 * k < nbits) begin
        if (word[2*k +: 2] != PAIR_ZERO &&
            word[2*k +: 2] != PAIR_ONE)
          ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/manchester_tx_serializer_timer.sv
// Half-bit timer: counts DIV cycles per half-bit.
// Ports: clk, rst, load (restart), en (run), tick (end strobe).
module halfbit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // With DIV=1 the counter is never consulted.
  assign tick = (DIV == 1) ? en : (en && cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || load)
      cnt <= TOP;
    else if (en)
      cnt <= (cnt == '0) ? TOP : cnt - 1'b1;
  end

endmodule

// File: rtl/manchester_tx_serializer.sv
// Manchester TX serializer: validates a word, sends preamble+data.
// Ports: clk, rst, in_valid/in_ready/in_word, abort, line_out, line_en, busy, done, err.
module manchester_tx_serializer
  import manchester_pkg::*;
#(
  parameter int   WORD_W   = 16,
  parameter int   DIV      = 4,
  parameter int   PRE_LEN  = 2,
  parameter int   GAP_HB   = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              abort,
  output logic              line_out,
  output logic              line_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int HB_A   = (2 * PRE_LEN > WORD_W) ? 2 * PRE_LEN : WORD_W;
  localparam int HB_MAX = (HB_A > GAP_HB) ? HB_A : GAP_HB;
  localparam int HW     = (HB_MAX > 1) ? $clog2(HB_MAX) : 1;

  localparam logic [HW-1:0] PRE_TOP  = HW'(2 * PRE_LEN - 1);
  localparam logic [HW-1:0] DATA_TOP = HW'(WORD_W - 1);
  localparam logic [HW-1:0] GAP_TOP  = HW'(GAP_HB - 1);

  state_t            state;
  logic [HW-1:0]     hb;
  logic [HW-1:0]     hb_dec;
  logic [WORD_W-1:0] shreg;
  logic              accept;
  logic              word_ok;
  logic              sending;
  logic              cut;
  logic              load;
  logic              tick;

  assign in_ready = (state == S_IDLE) && !rst;
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;
  assign word_ok  = is_valid_manchester(MAX_W'(in_word), WORD_W);
  assign sending  = (state == S_PRE) || (state == S_DATA);
  assign cut      = sending && abort;
  assign load     = (accept && word_ok) || cut;
  assign hb_dec   = hb - 1'b1;

  halfbit_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (busy),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hb       <= '0;
      shreg    <= '0;
      line_out <= IDLE_LVL;
      line_en  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (word_ok) begin
              state    <= S_PRE;
              hb       <= PRE_TOP;
              shreg    <= in_word;
              line_out <= 1'b1;
              line_en  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_PRE: begin
          if (abort) begin
            state    <= S_GAP;
            hb       <= GAP_TOP;
            line_en  <= 1'b0;
            line_out <= IDLE_LVL;
          end else if (tick) begin
            if (hb == '0) begin
              state    <= S_DATA;
              hb       <= DATA_TOP;
              line_out <= shreg[WORD_W-1];
              shreg    <= shreg << 1;
            end else begin
              hb       <= hb_dec;
              line_out <= PRE_PAIR[hb_dec[0]];
            end
          end
        end
        S_DATA: begin
          if (abort) begin
            state    <= S_GAP;
            hb       <= GAP_TOP;
            line_en  <= 1'b0;
            line_out <= IDLE_LVL;
          end else if (tick) begin
            if (hb == '0) begin
              state    <= S_GAP;
              hb       <= GAP_TOP;
              line_en  <= 1'b0;
              line_out <= IDLE_LVL;
              done     <= 1'b1;
            end else begin
              hb       <= hb_dec;
              line_out <= shreg[WORD_W-1];
              shreg    <= shreg << 1;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (hb == '0)
              state <= S_IDLE;
            else
              hb <= hb_dec;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
